if_pc_queue: RTL

Parametrised fetch-side PC tracker that keeps every returned instruction paired with the PC that requested it, for up to DEPTH outstanding instruction-memory requests. It sits between PC generation and instruction memory on the request side, and in front of the IF/ID register on the response side. On a branch flush it clears the queue and silently discards responses still in flight for squashed requests. It generalises the single-entry IF PC buffer: configurable depth, outstanding-request accounting, response dropping and an error flag.

---
 rtl/if_pc_queue_pkg.sv | 18 +
 rtl/if_pc_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_pc_queue_pkg.sv
// Shared constants and types for the fetch-side PC queue.
// The constants mirror the global fetch defines so the queue stays self-contained.
package if_pc_queue_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        INST_VALID   = 1'b1;
    localparam logic        INST_INVALID = 1'b0;
    localparam logic        BRANCH       = 1'b1;

    // What a returning memory response does to the queue this cycle
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_DROP = 2'd1,
        RESP_POP  = 2'd2,
        RESP_ERR  = 2'd3
    } resp_kind_e;

endpackage : if_pc_queue_pkg

// File: rtl/if_pc_queue.sv
// Tracks up to DEPTH outstanding fetches so each returned instruction leaves paired with its PC.
// A flush converts live entries into owed drops so squashed responses are silently discarded.
module if_pc_queue
    import if_pc_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    input  logic [ADDR_WIDTH-1:0]         req_pc_i,
    output logic                          req_ready_o,
    input  logic                          resp_valid_i,
    input  logic [INST_WIDTH-1:0]         resp_inst_i,
    input  logic                          branch_flag_i,
    output logic [ADDR_WIDTH-1:0]         pc_o,
    output logic [INST_WIDTH-1:0]         inst_o,
    output logic                          inst_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          proto_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_mem_r [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      drop_cnt_r;

    logic [CNT_W:0]        outstanding_s;
    logic [CNT_W:0]        flush_drop_s;
    logic                  flush_s;
    logic                  req_ready_s;
    logic                  push_s;
    logic                  pop_s;
    resp_kind_e            resp_kind_s;

    // Request acceptance and classification of the incoming response
    always_comb begin
        outstanding_s = {1'b0, count_r} + {1'b0, drop_cnt_r};
        flush_s       = (branch_flag_i == BRANCH);
        req_ready_s   = !flush_s && (outstanding_s < (CNT_W + 1)'(DEPTH));
        push_s        = req_valid_i && req_ready_s;
        if (!resp_valid_i) begin
            resp_kind_s = RESP_NONE;
        end else if (drop_cnt_r != {CNT_W{1'b0}}) begin
            resp_kind_s = RESP_DROP;
        end else if (count_r != {CNT_W{1'b0}}) begin
            resp_kind_s = RESP_POP;
        end else begin
            resp_kind_s = RESP_ERR;
        end
        pop_s = (resp_kind_s == RESP_POP);
        // A response arriving with the flush retires the oldest owed slot
        if (resp_valid_i && (outstanding_s != {(CNT_W + 1){1'b0}})) begin
            flush_drop_s = outstanding_s - {{CNT_W{1'b0}}, 1'b1};
        end else begin
            flush_drop_s = outstanding_s;
        end
    end

    assign req_ready_o = req_ready_s;
    assign count_o     = count_r;

    // PC storage; written only on an accepted request
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r] <= req_pc_i;
        end
    end

    // Pointer, live-count and owed-drop bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            rd_ptr_r   <= wr_ptr_r;
            count_r    <= {CNT_W{1'b0}};
            drop_cnt_r <= flush_drop_s[CNT_W-1:0];
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            case (resp_kind_s)
                RESP_POP:  rd_ptr_r   <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
                RESP_DROP: drop_cnt_r <= drop_cnt_r - {{(CNT_W - 1){1'b0}}, 1'b1};
                default:   drop_cnt_r <= drop_cnt_r;
            endcase
        end
    end

    // Registered decode-side outputs and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o         <= {ADDR_WIDTH{1'b0}};
            inst_o       <= {INST_WIDTH{1'b0}};
            inst_valid_o <= INST_INVALID;
            proto_err_o  <= 1'b0;
        end else begin
            proto_err_o <= proto_err_o | (resp_kind_s == RESP_ERR);
            if (flush_s) begin
                pc_o         <= {ADDR_WIDTH{1'b0}};
                inst_o       <= {INST_WIDTH{1'b0}};
                inst_valid_o <= INST_INVALID;
            end else begin
                case (resp_kind_s)
                    RESP_POP: begin
                        pc_o         <= pc_mem_r[rd_ptr_r];
                        inst_o       <= resp_inst_i;
                        inst_valid_o <= INST_VALID;
                    end
                    default: inst_valid_o <= INST_INVALID;
                endcase
            end
        end
    end

endmodule : if_pc_queue
